alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Upstream command stage for the 8-bit ALU (opermux). It buffers opcode/operand commands from a producer, issues each command to the ALU as a single-cycle enable pulse with stable selector/data, and waits a fixed settle time. For opcodes that produce a value, it captures the ALU result Y and returns it on a valid/ready result port.

## Interface
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- SETTLE_CYCLES, 2, cycles between enable pulse and Y capture (≥1)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_op  in  4  ALU selector code
- cmd_data  in  8  signed operand (used by op 0xF)
- alu_selector  out  4  to ALU selector
- alu_data_in  out  8  to ALU data_in
- alu_enable  out  1  one-cycle issue pulse
- alu_y  in  8  signed ALU result Y
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  captured Y
- res_op  out  4  opcode that produced res_data
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Push on the clk edge where cmd_valid && cmd_ready. cmd_ready = !full and is registered-state only, with no combinational dependence on pop.
- Result opcodes are 0x0–0xC. Non-result opcodes are 0xD (A=Y), 0xE (swap) and 0xF (load); they issue but produce no result beat.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into op_r/data_r and go to ISSUE.
  - ISSUE: alu_enable=1 for exactly this cycle. Load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement the counter. At 0:
    - result op: register alu_y into res_data and op_r into res_op, set res_valid, go to RESP.
    - otherwise: go to IDLE.
  - RESP: hold until res_valid && res_ready, then clear res_valid and go to IDLE.
- alu_selector and alu_data_in update only on entry to ISSUE. They hold through SETTLE, RESP and IDLE until the next issue.
- res_data and res_op are stable while res_valid=1.
- Simultaneous push and pop at any count: both take effect and the count is unchanged. A push when full is impossible because cmd_ready=0.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset (async, any state) has these effects:
  - FIFO emptied, FSM forced to IDLE.
  - res_valid, alu_enable, alu_selector, alu_data_in, res_data, res_op and fifo_count all 0.
  - busy=0, cmd_ready=1.
  - An in-flight command or result is discarded and never produces a result beat.
- The ALU's own reset is separate and not driven by this block.

## Timing
- The command is accepted at edge E0 into an empty, idle block.
- Pop and IDLE→ISSUE at E1. alu_enable is high during the E1–E2 cycle.
- SETTLE occupies SETTLE_CYCLES cycles. Y is captured and res_valid is visible after edge E(2+SETTLE_CYCLES), which is E4 at the default.
- A res handshake at edge Ek returns the FSM to IDLE. The next queued command pops at Ek+1.
- Minimum issue interval:
  - result op with res_ready held 1: 3+SETTLE_CYCLES cycles.
  - non-result op: 2+SETTLE_CYCLES cycles.
- Up to FIFO_DEPTH+1 commands can be outstanding: one in the FSM plus FIFO_DEPTH queued.

## Structure
- The shared package alu_pkg holds:
  - opcode localparams OP_ADD=0x0 … OP_LOAD=0xF
  - function has_result(op)
  - the FSM state encoding (IDLE, ISSUE, SETTLE, RESP)
- One sub-module, cmd_fifo: a synchronous FIFO of {op, data} entries, 12 bits wide, with FIFO_DEPTH entries. It has push/pop/full/empty/count and an asynchronous active-low reset.
- FSM, settle counter and result register live in the top.

## Test plan
- Load command:
  - Stimulus: push op=0xF, data=0x05.
  - Response: one alu_enable pulse with selector=0xF and data_in=0x05; res_valid never asserts; busy falls after E(2+SETTLE_CYCLES).
- Add command:
  - Stimulus: ALU model gives Y=0x0C (A=5, B=7); push op=0x0; res_ready=1.
  - Response: res_valid high exactly 4 cycles after acceptance, with res_data=0x0C and res_op=0x0.
- Fill and backpressure:
  - Stimulus: res_ready=0; offer op=0x5 continuously.
  - Response: exactly 5 accepts, then cmd_ready=0 and fifo_count=4. res_data stays constant for 10 cycles with no further alu_enable. Raising res_ready drains all 5 results in order.
- Mixed stream:
  - Stimulus: push 0xF(0x10), 0xE, 0x3.
  - Response: three enable pulses in order and a single result beat with res_op=0x3.
- Simultaneous push/pop at fifo_count=1:
  - Response: count stays 1 and order is preserved.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 mid-SETTLE with 2 entries queued.
  - Response: outputs 0 immediately (asynchronous) and fifo_count=0. After release, no res_valid and no alu_enable occur without new commands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the ALU command sequencer.
// Imported by the sequencer top and its command FIFO.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ASR  = 4'h8;
    localparam logic [3:0] OP_ROL  = 4'h9;
    localparam logic [3:0] OP_ROR  = 4'hA;
    localparam logic [3:0] OP_INC  = 4'hB;
    localparam logic [3:0] OP_DEC  = 4'hC;
    localparam logic [3:0] OP_MOVA = 4'hD;
    localparam logic [3:0] OP_SWAP = 4'hE;
    localparam logic [3:0] OP_LOAD = 4'hF;

    localparam int CMD_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        RESP
    } state_t;

    // Opcodes 0x0..0xC return a value on the result port.
    function automatic logic has_result(input logic [3:0] op);
        return op <= OP_DEC;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous {op, data} command FIFO with power-of-two depth.
// Head entry is visible combinationally on rdata.
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues each as a one-cycle enable pulse,
// waits the settle time and returns Y for value-producing opcodes.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  cmd_op,
    input  logic [7:0]                  cmd_data,
    output logic [3:0]                  alu_selector,
    output logic [7:0]                  alu_data_in,
    output logic                        alu_enable,
    input  logic [7:0]                  alu_y,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [7:0]                  res_data,
    output logic [3:0]                  res_op,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t         state;
    state_t         state_n;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [CMD_W-1:0] head;
    logic [3:0]     op_r;
    logic [7:0]     data_r;
    logic [CW-1:0]  cnt;
    logic           settle_done;

    assign cmd_ready    = !full;
    assign push         = cmd_valid && !full;
    assign pop          = (state == IDLE) && !empty;
    assign settle_done  = (state == SETTLE) && (cnt == '0);
    assign alu_enable   = state == ISSUE;
    assign alu_selector = op_r;
    assign alu_data_in  = data_r;
    assign busy         = (state != IDLE) || !empty;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   ({cmd_op, cmd_data}),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (!empty) state_n = ISSUE;
            ISSUE:  state_n = SETTLE;
            SETTLE: begin
                if (cnt == '0) state_n = has_result(op_r) ? RESP : IDLE;
            end
            RESP:   if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Selector/data only move on a pop, so they hold until the next issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r      <= '0;
            data_r    <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
        end else begin
            if (pop) begin
                op_r   <= head[11:8];
                data_r <= head[7:0];
            end
            if (state == ISSUE)
                cnt <= CW'(SETTLE_CYCLES - 1);
            else if (state == SETTLE && cnt != '0)
                cnt <= cnt - 1'b1;
            if (settle_done && has_result(op_r)) begin
                res_valid <= 1'b1;
                res_data  <= alu_y;
                res_op    <= op_r;
            end else if (state == RESP && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
